decode_issue_queue: RTL and testbench

//  Buffers fetched RV32I/RV32E instructions in a DEPTH-entry FIFO and decodes the head entry.

---
 rtl/decode_issue_queue.sv | 163 ++++++++++++++++
 tb/tb_decode_issue_queue.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_queue.sv
// decode_issue_queue: instruction FIFO whose head is decoded and issued, gated by a register scoreboard and a pending-jump hold
module decode_issue_queue #(
   parameter int DEPTH = 4,
   parameter int NREG  = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [31:0]              in_inst,
   input  logic [31:0]              in_pc,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic [2:0]               funct3,
   output logic [4:0]               rd,
   output logic [4:0]               rs1,
   output logic [4:0]               rs2,
   output logic [31:0]              imm,
   output logic [2:0]               alu_op,
   output logic [1:0]               addr_alu_op,
   output logic [1:0]               wb_op,
   output logic [1:0]               jmp_op,
   output logic [1:0]               mem_op,
   output logic                     fault,
   input  logic                     wb_valid,
   input  logic [4:0]               wb_rd,
   input  logic                     jmp_resolved,
   input  logic                     flush,
   output logic [NREG-1:0]          busy_reg,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   cnt_t;
   typedef logic [NREG-1:0] reg_t;
   localparam cnt_t       DEPTH_C = cnt_t'(DEPTH);
   localparam logic [5:0] NREG_C  = 6'(NREG);
   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
      OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
      OP_IMM = 7'b0010011, OP_REG = 7'b0110011, OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;

   logic [31:0] inst_q [DEPTH];
   logic [31:0] inst_d [DEPTH];
   logic [31:0] pc_q   [DEPTH];
   logic [31:0] pc_d   [DEPTH];
   ptr_t        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   cnt_t        count_q, count_d;
   reg_t        busy_q, busy_d, set_vec, clr_vec;
   logic        jmp_pending_q, jmp_pending_d;
   logic [31:0] head, busy32, imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [6:0]  opcode;
   logic        use_rd, use_rs1, use_rs2, bad_op, reg_oob, hazard, empty, push, pop;

   assign head     = inst_q[rd_ptr_q];
   assign out_pc   = pc_q[rd_ptr_q];
   assign opcode   = head[6:0];
   assign funct3   = head[14:12];
   assign rd       = head[11:7];
   assign rs1      = head[19:15];
   assign rs2      = head[24:20];
   assign imm_i    = {{20{head[31]}}, head[31:20]};
   assign imm_s    = {{20{head[31]}}, head[31:25], head[11:7]};
   assign imm_b    = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
   assign imm_u    = {head[31:12], 12'h000};
   assign imm_j    = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
   assign busy_reg = busy_q;
   assign count    = count_q;

   always_comb begin
      imm         = '0;
      alu_op      = 3'd0;
      addr_alu_op = 2'd0;
      wb_op       = 2'd0;
      jmp_op      = 2'd0;
      mem_op      = 2'd0;
      use_rd      = 1'b0;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
      bad_op      = 1'b0;
      case (opcode)
         OP_LUI:    begin imm = imm_u; wb_op = 2'd1; use_rd = 1'b1; end
         OP_AUIPC:  begin imm = imm_u; addr_alu_op = 2'd1; wb_op = 2'd2; use_rd = 1'b1; end
         OP_JAL:    begin
            imm = imm_j; alu_op = 3'd1; addr_alu_op = 2'd1; wb_op = 2'd1; jmp_op = 2'd1; use_rd = 1'b1;
         end
         OP_JALR:   begin
            imm = imm_i; alu_op = 3'd1; addr_alu_op = 2'd3; wb_op = 2'd1; jmp_op = 2'd1;
            use_rd = 1'b1; use_rs1 = 1'b1; bad_op = funct3 != 3'd0;
         end
         OP_BRANCH: begin
            imm = imm_b; alu_op = 3'd3; addr_alu_op = 2'd1; jmp_op = 2'd2; use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OP_LOAD:   begin
            imm = imm_i; addr_alu_op = 2'd2; wb_op = 2'd1; mem_op = 2'd1; use_rd = 1'b1; use_rs1 = 1'b1;
         end
         OP_STORE:  begin
            imm = imm_s; alu_op = 3'd4; addr_alu_op = 2'd2; mem_op = 2'd2; use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OP_IMM:    begin imm = imm_i; alu_op = 3'd5; wb_op = 2'd1; use_rd = 1'b1; use_rs1 = 1'b1; end
         OP_REG:    begin alu_op = 3'd6; wb_op = 2'd1; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OP_FENCE:  imm = imm_i;
         OP_SYSTEM: begin
            imm = imm_i; bad_op = (rd != 5'd0) | (rs1 != 5'd0) | (head[31:20] > 12'd1);
         end
         default:   bad_op = 1'b1;
      endcase
   end

   assign reg_oob = (use_rd & ({1'b0, rd} >= NREG_C)) | (use_rs1 & ({1'b0, rs1} >= NREG_C)) |
                    (use_rs2 & ({1'b0, rs2} >= NREG_C));
   assign fault   = bad_op | reg_oob;

   // zero-extended view so out-of-range fields on RV32E read as not busy
   always_comb begin
      busy32            = '0;
      busy32[NREG-1:0]  = busy_q;
   end

   assign hazard    = (use_rd & busy32[rd]) | (use_rs1 & busy32[rs1]) | (use_rs2 & busy32[rs2]);
   assign empty     = count_q == '0;
   assign in_ready  = count_q < DEPTH_C;
   assign out_valid = ~empty & ~hazard & ~jmp_pending_q & ~flush;
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready;

   always_comb begin
      inst_d = inst_q;
      pc_d   = pc_q;
      if (push) begin
         inst_d[wr_ptr_q] = in_inst;
         pc_d[wr_ptr_q]   = in_pc;
      end
      wr_ptr_d      = flush ? '0 : wr_ptr_q + ptr_t'(push);
      rd_ptr_d      = flush ? '0 : rd_ptr_q + ptr_t'(pop);
      count_d       = flush ? '0 : count_q + cnt_t'(push) - cnt_t'(pop);
      set_vec       = (pop && wb_op != 2'd0 && rd != 5'd0 && !fault) ? reg_t'(32'd1 << rd) : '0;
      clr_vec       = wb_valid ? reg_t'(32'd1 << wb_rd) : '0;
      busy_d        = (busy_q & ~clr_vec) | set_vec;
      jmp_pending_d = flush ? 1'b0 : (pop && jmp_op != 2'd0 && !fault) ? 1'b1 :
                      jmp_resolved ? 1'b0 : jmp_pending_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_q        <= '{default: '0};
         pc_q          <= '{default: '0};
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         busy_q        <= '0;
         jmp_pending_q <= 1'b0;
      end else begin
         inst_q        <= inst_d;
         pc_q          <= pc_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         busy_q        <= busy_d;
         jmp_pending_q <= jmp_pending_d;
      end
   end
endmodule

// File: tb/tb_decode_issue_queue.sv
// tb_decode_issue_queue: directed scenarios plus randomized traffic against a queue-based reference model
module tb_decode_issue_queue;
   localparam int DEPTH = 4;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [31:0] in_inst = '0, in_pc = '0;
   logic        in_valid = 1'b0, out_ready = 1'b0, wb_valid = 1'b0, jmp_resolved = 1'b0, flush = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic        in_ready, out_valid, fault;
   logic [31:0] out_pc, imm;
   logic [2:0]  funct3, alu_op;
   logic [4:0]  rd, rs1, rs2;
   logic [1:0]  addr_alu_op, wb_op, jmp_op, mem_op;
   logic [31:0] busy_reg;
   logic [2:0]  count;
   logic        e_in_ready, e_out_valid, e_fault;
   logic [31:0] e_out_pc, e_imm;
   logic [2:0]  e_funct3, e_alu_op;
   logic [4:0]  e_rd, e_rs1, e_rs2;
   logic [1:0]  e_addr_alu_op, e_wb_op, e_jmp_op, e_mem_op;
   logic [15:0] e_busy_reg;
   logic [2:0]  e_count;
   int n_checks = 0, n_fail = 0;

   typedef struct {
      logic [31:0] imm;
      logic [31:0] used;
      logic [2:0]  alu;
      logic [1:0]  addr, wb, jmp, mem;
      logic        fault;
   } dec_t;

   decode_issue_queue #(.DEPTH(DEPTH), .NREG(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_inst(in_inst), .in_pc(in_pc), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .funct3(funct3), .rd(rd), .rs1(rs1),
      .rs2(rs2), .imm(imm), .alu_op(alu_op), .addr_alu_op(addr_alu_op), .wb_op(wb_op), .jmp_op(jmp_op),
      .mem_op(mem_op), .fault(fault), .wb_valid(wb_valid), .wb_rd(wb_rd), .jmp_resolved(jmp_resolved),
      .flush(flush), .busy_reg(busy_reg), .count(count));

   decode_issue_queue #(.DEPTH(DEPTH), .NREG(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_inst(in_inst), .in_pc(in_pc), .in_valid(in_valid), .in_ready(e_in_ready),
      .out_valid(e_out_valid), .out_ready(out_ready), .out_pc(e_out_pc), .funct3(e_funct3), .rd(e_rd),
      .rs1(e_rs1), .rs2(e_rs2), .imm(e_imm), .alu_op(e_alu_op), .addr_alu_op(e_addr_alu_op), .wb_op(e_wb_op),
      .jmp_op(e_jmp_op), .mem_op(e_mem_op), .fault(e_fault), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .jmp_resolved(jmp_resolved), .flush(flush), .busy_reg(e_busy_reg), .count(e_count));

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_addi(input logic [4:0] d, input logic [4:0] s, input logic [11:0] k);
      return {k, s, 3'b000, d, 7'b0010011};
   endfunction

   function automatic logic [31:0] enc_add(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
      return {7'b0, b, a, 3'b000, d, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_jal(input logic [4:0] d, input logic [20:0] off);
      return {off[20], off[10:1], off[11], off[19:12], d, 7'b1101111};
   endfunction

   function automatic dec_t ref_decode(input logic [31:0] w, input int nreg);
      dec_t d;
      byte  fmt;
      logic u_rd, u_rs1, u_rs2;
      d = '{default: '0};
      fmt = "X";
      case (w[6:0])
         7'h37: begin fmt = "U"; d.wb = 1; end
         7'h17: begin fmt = "U"; d.addr = 1; d.wb = 2; end
         7'h6f: begin fmt = "J"; d.alu = 1; d.addr = 1; d.wb = 1; d.jmp = 1; end
         7'h67: begin fmt = "I"; d.alu = 1; d.addr = 3; d.wb = 1; d.jmp = 1; d.fault = w[14:12] != 0; end
         7'h63: begin fmt = "B"; d.alu = 3; d.addr = 1; d.jmp = 2; end
         7'h03: begin fmt = "I"; d.addr = 2; d.mem = 1; d.wb = 1; end
         7'h23: begin fmt = "S"; d.alu = 4; d.addr = 2; d.mem = 2; end
         7'h13: begin fmt = "I"; d.alu = 5; d.wb = 1; end
         7'h33: begin fmt = "R"; d.alu = 6; d.wb = 1; end
         7'h0f: fmt = "i";
         7'h73: begin fmt = "i"; d.fault = (w[11:7] != 0) || (w[19:15] != 0) || (w[31:20] > 1); end
         default: d.fault = 1;
      endcase
      case (fmt)
         "I", "i": d.imm = 32'($signed(w[31:20]));
         "S": d.imm = 32'($signed({w[31:25], w[11:7]}));
         "B": d.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
         "U": d.imm = {w[31:12], 12'h000};
         "J": d.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
         default: d.imm = 0;
      endcase
      u_rd  = fmt inside {"R", "I", "U", "J"};
      u_rs1 = fmt inside {"R", "I", "S", "B"};
      u_rs2 = fmt inside {"R", "S", "B"};
      if ((u_rd && w[11:7] >= nreg) || (u_rs1 && w[19:15] >= nreg) || (u_rs2 && w[24:20] >= nreg)) d.fault = 1;
      d.used = (u_rd ? 32'd1 << w[11:7] : 0) | (u_rs1 ? 32'd1 << w[19:15] : 0) | (u_rs2 ? 32'd1 << w[24:20] : 0);
      return d;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      logic [6:0]  ops [11];
      int          k;
      ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
      w = $urandom;
      k = $urandom_range(0, 13);
      if (k < 11) begin
         w[6:0]   = ops[k];
         w[11:7]  = 5'($urandom_range(0, 7));
         w[19:15] = 5'($urandom_range(0, 7));
         w[24:20] = 5'($urandom_range(0, 7));
         if (k == 3 && $urandom_range(0, 4) != 0) w[14:12] = 3'd0;
      end else if (k == 11) w = 32'h0000_0073;
      else if (k == 12) w = 32'h0010_0073;
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 0; out_ready = 0; wb_valid = 0; jmp_resolved = 0; flush = 0; wb_rd = 0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
      n_checks++; if (busy_reg !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy_reg); end
   endtask

   task automatic test_raw_hazard();
      do_reset();
      in_valid = 1; in_inst = enc_addi(5'd1, 5'd0, 12'd5); in_pc = 32'h100; out_ready = 1;
      tick();
      in_inst = enc_add(5'd2, 5'd1, 5'd1); in_pc = 32'h104;
      #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL raw_addi_valid: got %0b want 1", out_valid); end
      n_checks++; if (imm !== 32'd5 || rd !== 5'd1) begin n_fail++; $display("FAIL raw_addi_fields: imm %h rd %0d want 5/1", imm, rd); end
      n_checks++; if (alu_op !== 3'd5 || wb_op !== 2'd1 || out_pc !== 32'h100) begin n_fail++; $display("FAIL raw_addi_ops: alu %0d wb %0d pc %h", alu_op, wb_op, out_pc); end
      tick();
      in_valid = 0;
      #1;
      n_checks++; if (busy_reg !== 32'h2) begin n_fail++; $display("FAIL raw_busy_set: got %h want 2", busy_reg); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_add_held: got %0b want 0", out_valid); end
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL raw_count: got %0d want 1", count); end
      tick();
      wb_valid = 1; wb_rd = 5'd1;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_add_held2: got %0b want 0", out_valid); end
      tick();
      wb_valid = 0;
      #1;
      n_checks++; if (busy_reg !== 32'h0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL raw_release: busy %h valid %0b want 0/1", busy_reg, out_valid); end
      n_checks++; if (alu_op !== 3'd6 || rd !== 5'd2 || rs1 !== 5'd1 || rs2 !== 5'd1) begin n_fail++; $display("FAIL raw_add_fields: alu %0d rd %0d rs1 %0d rs2 %0d", alu_op, rd, rs1, rs2); end
      tick();
      n_checks++; if (busy_reg !== 32'h4 || count !== 3'd0) begin n_fail++; $display("FAIL raw_add_issued: busy %h count %0d want 4/0", busy_reg, count); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i <= DEPTH; i++) begin
         in_valid = 1; in_inst = enc_addi(5'd0, 5'd0, 12'(i + 1)); in_pc = 32'h200 + 32'(4 * i);
         #1;
         n_checks++; if (in_ready !== (i < DEPTH)) begin n_fail++; $display("FAIL fill_in_ready[%0d]: got %0b want %0b", i, in_ready, i < DEPTH); end
         tick();
      end
      in_valid = 0;
      #1;
      n_checks++; if (count !== 3'(DEPTH) || in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: count %0d ready %0b", count, in_ready); end
      out_ready = 1;
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 + 32'(4 * i) || imm !== 32'(i + 1)) begin
            n_fail++; $display("FAIL fill_drain[%0d]: valid %0b pc %h imm %h", i, out_valid, out_pc, imm);
         end
         tick();
      end
      n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_empty: count %0d valid %0b", count, out_valid); end
   endtask

   task automatic test_jump();
      do_reset();
      in_valid = 1; in_inst = enc_jal(5'd1, 21'd8); in_pc = 32'h300; out_ready = 1;
      tick();
      in_inst = enc_addi(5'd5, 5'd0, 12'd7); in_pc = 32'h304;
      #1;
      n_checks++; if (out_valid !== 1'b1 || jmp_op !== 2'd1 || imm !== 32'd8 || alu_op !== 3'd1) begin
         n_fail++; $display("FAIL jal_decode: valid %0b jmp %0d imm %h alu %0d", out_valid, jmp_op, imm, alu_op);
      end
      tick();
      in_valid = 0;
      #1;
      n_checks++; if (out_valid !== 1'b0 || count !== 3'd1 || busy_reg !== 32'h2) begin
         n_fail++; $display("FAIL jal_pending: valid %0b count %0d busy %h", out_valid, count, busy_reg);
      end
      tick();
      jmp_resolved = 1;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL jal_still_held: got %0b want 0", out_valid); end
      tick();
      jmp_resolved = 0;
      #1;
      n_checks++; if (out_valid !== 1'b1 || rd !== 5'd5 || out_pc !== 32'h304) begin n_fail++; $display("FAIL jal_release: valid %0b rd %0d pc %h", out_valid, rd, out_pc); end
      tick();
      n_checks++; if (count !== 3'd0 || busy_reg !== 32'h22) begin n_fail++; $display("FAIL jal_after: count %0d busy %h", count, busy_reg); end
   endtask

   task automatic test_flush();
      do_reset();
      out_ready = 1; in_valid = 1; in_inst = enc_addi(5'd3, 5'd0, 12'd1); in_pc = 32'h400;
      tick();
      in_inst = enc_jal(5'd0, 21'd8); in_pc = 32'h404;
      tick();
      for (int i = 0; i < 3; i++) begin
         in_inst = enc_addi(5'd0, 5'd0, 12'(i)); in_pc = 32'h408 + 32'(4 * i);
         tick();
      end
      in_inst = enc_addi(5'd4, 5'd0, 12'd9); flush = 1;
      #1;
      n_checks++; if (count !== 3'd3 || out_valid !== 1'b0 || busy_reg !== 32'h8) begin
         n_fail++; $display("FAIL flush_before: count %0d valid %0b busy %h", count, out_valid, busy_reg);
      end
      tick();
      flush = 0; in_valid = 0;
      #1;
      n_checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after: count %0d valid %0b ready %0b", count, out_valid, in_ready); end
      n_checks++; if (busy_reg !== 32'h8) begin n_fail++; $display("FAIL flush_busy_kept: got %h want 8", busy_reg); end
      in_valid = 1; in_inst = enc_addi(5'd4, 5'd0, 12'd1); out_ready = 0;
      tick();
      in_valid = 0;
      #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_jmp_cleared: got %0b want 1", out_valid); end
   endtask

   task automatic test_rv32e();
      do_reset();
      in_valid = 1; in_inst = enc_add(5'd17, 5'd1, 5'd2);
      tick();
      in_valid = 0;
      #1;
      n_checks++; if (e_out_valid !== 1'b1 || e_fault !== 1'b1) begin n_fail++; $display("FAIL e_fault: valid %0b fault %0b want 1/1", e_out_valid, e_fault); end
      n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL i_nofault: got %0b want 0", fault); end
      out_ready = 1;
      tick();
      out_ready = 0;
      n_checks++; if (e_busy_reg !== 16'h0 || e_count !== 3'd0) begin n_fail++; $display("FAIL e_issue: busy %h count %0d want 0/0", e_busy_reg, e_count); end
      n_checks++; if (busy_reg !== 32'h0002_0000) begin n_fail++; $display("FAIL i_busy17: got %h want 00020000", busy_reg); end
   endtask

   task automatic test_wb_same_edge();
      do_reset();
      in_valid = 1; in_inst = enc_addi(5'd3, 5'd0, 12'd2);
      tick();
      in_valid = 0; out_ready = 1; wb_valid = 1; wb_rd = 5'd3;
      #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL same_edge_valid: got %0b want 1", out_valid); end
      tick();
      wb_valid = 0; out_ready = 0;
      n_checks++; if (busy_reg !== 32'h8) begin n_fail++; $display("FAIL same_edge_set_wins: got %h want 8", busy_reg); end
      wb_valid = 1;
      tick();
      wb_valid = 0;
      n_checks++; if (busy_reg !== 32'h0) begin n_fail++; $display("FAIL wb_clear: got %h want 0", busy_reg); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      in_valid = 1; in_inst = enc_addi(5'd6, 5'd0, 12'd1); out_ready = 1;
      tick();
      in_inst = enc_addi(5'd0, 5'd0, 12'd2);
      tick();
      out_ready = 0;
      tick();
      in_valid = 0;
      #1;
      n_checks++; if (busy_reg !== 32'h40 || count !== 3'd2) begin n_fail++; $display("FAIL mid_before: busy %h count %0d", busy_reg, count); end
      rst_n = 0;
      #1;
      n_checks++; if (busy_reg !== 32'h0 || count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL mid_async_reset: busy %h count %0d ready %0b valid %0b", busy_reg, count, in_ready, out_valid);
      end
      do_reset();
   endtask

   task automatic test_random();
      logic [63:0] q[$];
      logic [31:0] busy, set, clr;
      logic        jp, hz, exp_v, iss;
      dec_t        d;
      int          sz;
      do_reset();
      busy = 0; jp = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         in_valid = $urandom_range(0, 2) != 0; in_inst = rand_inst(); in_pc = $urandom;
         out_ready = $urandom_range(0, 3) != 0;
         wb_valid = $urandom_range(0, 2) == 0; wb_rd = 5'($urandom_range(0, 7));
         jmp_resolved = $urandom_range(0, 3) == 0;
         flush = $urandom_range(0, 40) == 0;
         #1;
         d = '{default: '0};
         if (q.size() != 0) d = ref_decode(q[0][31:0], 32);
         hz = (q.size() != 0) && ((d.used & busy) != 0);
         exp_v = (q.size() != 0) && !hz && !jp && !flush;
         n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL rnd_out_valid @%0d: got %0b want %0b", cyc, out_valid, exp_v); end
         n_checks++; if (in_ready !== (q.size() < DEPTH) || count !== 3'(q.size())) begin
            n_fail++; $display("FAIL rnd_occupancy @%0d: ready %0b count %0d want size %0d", cyc, in_ready, count, q.size());
         end
         n_checks++; if (busy_reg !== busy) begin n_fail++; $display("FAIL rnd_busy @%0d: got %h want %h", cyc, busy_reg, busy); end
         if (q.size() != 0) begin
            n_checks++; if (out_pc !== q[0][63:32] || imm !== d.imm || fault !== d.fault) begin
               n_fail++; $display("FAIL rnd_head @%0d inst %h: pc %h imm %h fault %0b want %h %h %0b", cyc, q[0][31:0], out_pc, imm, fault, q[0][63:32], d.imm, d.fault);
            end
            n_checks++; if (alu_op !== d.alu || addr_alu_op !== d.addr || wb_op !== d.wb || jmp_op !== d.jmp || mem_op !== d.mem) begin
               n_fail++; $display("FAIL rnd_ops @%0d inst %h: %0d %0d %0d %0d %0d want %0d %0d %0d %0d %0d", cyc, q[0][31:0], alu_op, addr_alu_op, wb_op, jmp_op, mem_op, d.alu, d.addr, d.wb, d.jmp, d.mem);
            end
         end
         iss = exp_v && out_ready;
         set = (iss && d.wb != 0 && !d.fault && q[0][11:7] != 0) ? 32'd1 << q[0][11:7] : 0;
         clr = wb_valid ? 32'd1 << wb_rd : 0;
         busy = (busy & ~clr) | set;
         if (flush) jp = 0;
         else if (iss && d.jmp != 0 && !d.fault) jp = 1;
         else if (jmp_resolved) jp = 0;
         sz = q.size();
         if (flush) q.delete();
         else begin
            if (iss) void'(q.pop_front());
            if (in_valid && sz < DEPTH) q.push_back({in_pc, in_inst});
         end
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_raw_hazard();
      test_fill();
      test_jump();
      test_flush();
      test_rv32e();
      test_wb_same_edge();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
